// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO with combinational read data.
// It pops a word whenever it is idle or finishing the final stop bit, then
// sends start bit, DATA_SIZE data bits LSB-first, optional even parity and
// STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
module fifo_uart_tx #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Wide enough for both the data-bit index and the stop-bit index.
    localparam int BW = $clog2(DATA_SIZE + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_SIZE - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        baud_reg, baud_next;
    logic [BW-1:0]        bit_reg, bit_next;
    logic [DATA_SIZE-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 tx_reg, tx_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 bit_end;
    logic                 pop_slot;

    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;

    // State, counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic, pop request, and the next values of the output
    // registers (derived from the next state so they line up with it).
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;

        bit_end  = (baud_reg == BAUD_LAST);
        pop_slot = (state_reg == IDLE) ||
                   ((state_reg == STOP) && bit_end && (bit_reg == STOP_LAST));
        fifo_pop = pop_slot && enable && !fifo_empty && !rst;

        if (state_reg != IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == DATA_LAST) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    bit_next   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_reg == STOP_LAST) begin
                        state_next = IDLE;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase

        // A pop overrides everything: load the word and start a new frame.
        if (fifo_pop) begin
            shift_next  = fifo_data;
            parity_next = ^fifo_data;
            state_next  = START;
            baud_next   = '0;
            bit_next    = '0;
        end

        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (baud_next == BAUD_LAST) &&
                    (bit_next == STOP_LAST);
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter on the read side of the team's synchronous FIFO. Pops one word whenever it is idle and the FIFO is non-empty, then shifts it out LSB-first as an asynchronous UART frame: start bit, data, optional even parity, stop bit(s). It relies on the FIFO's combinational read, where read data is valid in the same cycle that pop is asserted.

## Interface
- DATA_SIZE, 8, data bits per frame; must match the FIFO word width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- enable  input  1  permits new pops; a frame already in progress always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_SIZE  FIFO read data; valid in the cycle fifo_pop is high.
- fifo_pop  output  1  combinational pop request to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop slot: the cycle is a pop slot when the block is in IDLE, or in the last cycle of the final stop bit.
- fifo_pop = pop slot AND enable AND !fifo_empty AND !rst. This is the only path that asserts fifo_pop.
- In a cycle with fifo_pop high:
  - fifo_data is captured into the shift register.
  - Parity is computed as the XOR of fifo_data.
  - The state moves to START, and the baud counter and bit counter clear.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - The bit-end event occurs at count CLKS_PER_BIT-1; the counter wraps to 0 on that event.
- Bit counter: counts 0 to DATA_SIZE-1 in DATA and 0 to STOP_BITS-1 in STOP.
- Transitions, each taken on a bit-end event:
  - START → DATA.
  - DATA, after bit DATA_SIZE-1 → PARITY if PARITY_EN = 1, else → STOP.
  - PARITY → STOP.
  - STOP, after the last stop bit → START if a pop occurred in that cycle, else → IDLE.
- tx is registered and set according to the state:
  - 1 in IDLE.
  - 0 in START.
  - shift_reg[0] in DATA; the register shifts right at each DATA bit-end.
  - the parity bit in PARITY.
  - 1 in STOP.
- busy is registered: high in START, DATA, PARITY and STOP, low in IDLE.
- frame_done is registered; it is high for exactly one cycle per frame.
- enable low:
  - No new pops occur.
  - The current frame finishes normally, then the block enters IDLE.
- fifo_empty rising mid-frame has no effect until the next pop slot.
- Reset:
  - Valid at any time, including mid-frame.
  - The next edge forces IDLE, tx = 1, busy = 0, frame_done = 0 and clears all counters. The partial frame is abandoned.
  - fifo_pop is held 0 while rst is high, so no FIFO word is consumed during reset.

## Timing
- Reset values: tx = 1, busy = 0, frame_done = 0. fifo_pop = 0 while rst is asserted.
- Pop in cycle T:
  - tx falls and busy rises at the edge ending cycle T.
  - The start bit occupies cycles T+1 .. T+CLKS_PER_BIT.
- Each bit is held for exactly CLKS_PER_BIT cycles.
- Frame length F = (1 + DATA_SIZE + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- frame_done is high in cycle T+F, which is also the next pop slot.
- Back-to-back frames have no idle gap: with the FIFO non-empty, pops occur at T, T+F, T+2F, and so on.
- Otherwise, at most one pop per cycle and at most one pop per frame.
- When the FIFO goes non-empty while the block is in IDLE, the pop happens in that same cycle (combinational).

## Test plan
- Single frame (CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1):
  - Stimulus: push 0xA5 into an empty FIFO.
  - Required response: one pop; tx shows 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles; frame_done high in pop+40; busy low afterward.
- Parity and two stop bits (PARITY_EN=1, STOP_BITS=2):
  - Stimulus: send 0x07.
  - Required response: parity bit 1; frame of 48 cycles; stop held high for 8 cycles.
  - Stimulus: send 0x03.
  - Required response: parity bit 0.
- Back-to-back:
  - Stimulus: preload 0x11, 0x22, 0x33 with enable high.
  - Required response: pops exactly 40 cycles apart; no idle-high gap between frames; frame_done ×3; FIFO empty after the third pop.
- Enable gating:
  - Stimulus: deassert enable mid-frame with 2 words queued.
  - Required response: current frame completes; no pop until enable returns; the first pop follows in the same cycle enable rises while the block is in IDLE.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3.
  - Required response: next edge gives tx = 1, busy = 0; no pop while rst is high; after release, the next queued word is sent as a complete frame.
- Empty FIFO:
  - Stimulus: enable high, fifo_empty high for 100 cycles.
  - Required response: fifo_pop never asserts; tx stays 1; busy stays 0.
